btn_conditioner: RTL

- Conditions the four raw push-buttons (up, down, right, left) before they reach the stopwatch/watch control unit.
- Each channel is synchronised, debounced on a shared millisecond tick, and converted into a single-cycle press pulse, a release pulse and a debounced level.
- Channels with repeat enabled also produce hold-to-repeat press pulses, so a held up/down button keeps stepping the edited time field.
- Sits directly upstream of the control unit; its o_press bits replace the raw button inputs.

---
 rtl/btn_pkg.sv | 22 ++
 rtl/btn_channel.sv | 133 +++++++++++++
 rtl/btn_conditioner.sv | 54 +++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package btn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DB_PRESS,
        S_PRESSED,
        S_REPEAT,
        S_DB_RELEASE
    } btn_state_t;

    localparam int TICK_DIV_DEF     = 100_000;
    localparam int DB_TICKS_DEF     = 10;
    localparam int HOLD_TICKS_DEF   = 500;
    localparam int REPEAT_TICKS_DEF = 100;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_RIGHT = 2;
    localparam int BTN_LEFT  = 3;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, tick-based debounce FSM,
// press/release pulse generation and hold-to-repeat.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DB_TICKS     = DB_TICKS_DEF,
    parameter int HOLD_TICKS   = HOLD_TICKS_DEF,
    parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic repeat_en,
    input  logic btn,
    output logic press_pulse,
    output logic release_pulse,
    output logic level,
    output logic hold
);

    localparam int DBW = $clog2(DB_TICKS + 1);
    localparam int HW  = $clog2(HOLD_TICKS + 1);
    localparam int RW  = $clog2(REPEAT_TICKS + 1);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_TICKS);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_TICKS);
    localparam logic [RW-1:0]  REP_LAST  = RW'(REPEAT_TICKS);

    logic [1:0]     sync_ff;
    logic           sync;
    btn_state_t     state, state_nxt;
    logic [DBW-1:0] db_cnt, db_nxt;
    logic [HW-1:0]  hold_cnt, hold_nxt;
    logic [RW-1:0]  rep_cnt, rep_nxt;
    logic           press_nxt, release_nxt, hold_flag_nxt;

    assign sync  = sync_ff[1];
    assign level = (state == S_PRESSED) || (state == S_REPEAT) || (state == S_DB_RELEASE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_ff       <= '0;
            state         <= S_IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold          <= 1'b0;
        end else begin
            sync_ff       <= {sync_ff[0], btn};
            state         <= state_nxt;
            db_cnt        <= db_nxt;
            hold_cnt      <= hold_nxt;
            rep_cnt       <= rep_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            hold          <= hold_flag_nxt;
        end
    end

    // Counters are compared on their registered value, so each threshold
    // acts one clk after the tick that reached it.
    always_comb begin
        state_nxt     = state;
        db_nxt        = db_cnt;
        hold_nxt      = hold_cnt;
        rep_nxt       = rep_cnt;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        hold_flag_nxt = hold;
        unique case (state)
            S_IDLE: begin
                db_nxt = '0;
                if (sync) state_nxt = S_DB_PRESS;
            end
            S_DB_PRESS: begin
                if (!sync) begin
                    state_nxt = S_IDLE;
                    db_nxt    = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt = S_PRESSED;
                    db_nxt    = '0;
                    hold_nxt  = '0;
                    press_nxt = 1'b1;
                end else if (tick) begin
                    db_nxt = db_cnt + 1'b1;
                end
            end
            S_PRESSED: begin
                db_nxt = '0;
                if (!sync) begin
                    state_nxt = S_DB_RELEASE;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt     = S_REPEAT;
                    rep_nxt       = '0;
                    hold_flag_nxt = 1'b1;
                    press_nxt     = repeat_en;
                end else if (tick) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            S_REPEAT: begin
                db_nxt = '0;
                if (!sync) begin
                    state_nxt = S_DB_RELEASE;
                end else if (rep_cnt == REP_LAST) begin
                    rep_nxt   = '0;
                    press_nxt = repeat_en;
                end else if (tick) begin
                    rep_nxt = rep_cnt + 1'b1;
                end
            end
            S_DB_RELEASE: begin
                if (sync) begin
                    state_nxt     = S_PRESSED;
                    db_nxt        = '0;
                    hold_nxt      = '0;
                    hold_flag_nxt = 1'b0;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt     = S_IDLE;
                    db_nxt        = '0;
                    release_nxt   = 1'b1;
                    hold_flag_nxt = 1'b0;
                end else if (tick) begin
                    db_nxt = db_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: rtl/btn_conditioner.sv
// Button conditioner: shared debounce-tick prescaler feeding one
// btn_channel per raw push-button input.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int               N_BTN        = 4,
    parameter int               TICK_DIV     = TICK_DIV_DEF,
    parameter int               DB_TICKS     = DB_TICKS_DEF,
    parameter int               HOLD_TICKS   = HOLD_TICKS_DEF,
    parameter int               REPEAT_TICKS = REPEAT_TICKS_DEF,
    parameter logic [N_BTN-1:0] REPEAT_EN    = 4'b0011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_hold
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_cnt;
    logic          tick;

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + 1'b1;
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_channel #(
            .DB_TICKS     (DB_TICKS),
            .HOLD_TICKS   (HOLD_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .tick          (tick),
            .repeat_en     (REPEAT_EN[i]),
            .btn           (i_btn[i]),
            .press_pulse   (o_press[i]),
            .release_pulse (o_release[i]),
            .level         (o_level[i]),
            .hold          (o_hold[i])
        );
    end

endmodule
